// File: rtl/bht_if.sv
// bht_if: lookup, prediction, training and statistics signals between the pipeline and the branch history table.
interface bht_if #(
  parameter int INDEX_BITS    = 6,
  parameter int PC_WIDTH      = 32,
  parameter int MISS_CNT_BITS = 16
);
  logic                     lookup_valid;
  logic [PC_WIDTH-1:0]      lookup_pc;
  logic                     pred_valid;
  logic                     pred_taken;
  logic                     pred_strong;
  logic [INDEX_BITS-1:0]    pred_index;
  logic                     upd_valid;
  logic [INDEX_BITS-1:0]    upd_index;
  logic                     upd_taken;
  logic                     upd_mispredict;
  logic [MISS_CNT_BITS-1:0] miss_count;
  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_index, upd_taken, upd_mispredict,
    input  pred_valid, pred_taken, pred_strong, pred_index, miss_count
  );
  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_index, upd_taken, upd_mispredict,
    output pred_valid, pred_taken, pred_strong, pred_index, miss_count
  );
endinterface

// File: rtl/bht_predictor.sv
// bht_predictor: table of saturating counters indexed by PC (optionally gshare-hashed) with registered prediction.
module bht_predictor #(
  parameter int CTR_BITS      = 2,
  parameter int INDEX_BITS    = 6,
  parameter int GHR_BITS      = 0,
  parameter int PC_WIDTH      = 32,
  parameter int PC_LSB        = 2,
  parameter int MISS_CNT_BITS = 16
) (
  input logic  clk,
  input logic  rst,
  bht_if.slave bus
);
  localparam int N  = 1 << INDEX_BITS;
  localparam int GW = GHR_BITS > 0 ? GHR_BITS : 1;
  logic [CTR_BITS-1:0]      r_ctr [N];
  logic [GW-1:0]            r_ghr;
  logic                     r_pred_valid;
  logic                     r_pred_taken;
  logic                     r_pred_strong;
  logic [INDEX_BITS-1:0]    r_pred_index;
  logic [MISS_CNT_BITS-1:0] r_miss;
  logic [INDEX_BITS-1:0]    w_idx;
  logic [CTR_BITS-1:0]      w_upd_cur;
  logic [CTR_BITS-1:0]      w_upd_next;
  logic [CTR_BITS-1:0]      w_lk_ctr;
  always_comb begin
    w_idx      = bus.lookup_pc[PC_LSB +: INDEX_BITS] ^ (GHR_BITS > 0 ? INDEX_BITS'(r_ghr) : '0);
    w_upd_cur  = r_ctr[bus.upd_index];
    w_upd_next = bus.upd_taken ? (&w_upd_cur ? w_upd_cur : w_upd_cur + 1'b1)
                               : (|w_upd_cur ? w_upd_cur - 1'b1 : w_upd_cur);
    // same-cycle training to the looked-up entry is forwarded into the prediction
    w_lk_ctr   = (bus.upd_valid && bus.upd_index == w_idx) ? w_upd_next : r_ctr[w_idx];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_ctr[i] <= CTR_BITS'(1) << (CTR_BITS - 1);
      r_ghr         <= '0;
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b1;
      r_pred_strong <= 1'b0;
      r_pred_index  <= '0;
      r_miss        <= '0;
    end else begin
      if (bus.upd_valid) begin
        r_ctr[bus.upd_index] <= w_upd_next;
        r_ghr                <= GHR_BITS > 0 ? GW'({r_ghr, bus.upd_taken}) : '0;
      end
      if (bus.upd_valid && bus.upd_mispredict && !(&r_miss)) r_miss <= r_miss + 1'b1;
      r_pred_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        r_pred_taken  <= w_lk_ctr[CTR_BITS-1];
        r_pred_strong <= &w_lk_ctr | ~|w_lk_ctr;
        r_pred_index  <= w_idx;
      end
    end
  end
  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_taken  = r_pred_taken;
  assign bus.pred_strong = r_pred_strong;
  assign bus.pred_index  = r_pred_index;
  assign bus.miss_count  = r_miss;
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: directed checks on a bimodal instance (3-bit miss counter) and a 4-bit gshare instance.
module tb_bht_predictor;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bht_if #(.INDEX_BITS(6), .PC_WIDTH(32), .MISS_CNT_BITS(3))  ia ();
  bht_if #(.INDEX_BITS(6), .PC_WIDTH(32), .MISS_CNT_BITS(16)) ib ();
  bht_predictor #(.CTR_BITS(2), .INDEX_BITS(6), .GHR_BITS(0), .PC_WIDTH(32), .PC_LSB(2), .MISS_CNT_BITS(3))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  bht_predictor #(.CTR_BITS(2), .INDEX_BITS(6), .GHR_BITS(4), .PC_WIDTH(32), .PC_LSB(2), .MISS_CNT_BITS(16))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic lv, input logic [31:0] pc, input logic uv,
                       input logic [5:0] ui, input logic ut, input logic um);
    ia.lookup_valid = lv; ia.lookup_pc = pc; ia.upd_valid = uv;
    ia.upd_index = ui; ia.upd_taken = ut; ia.upd_mispredict = um;
    ib.lookup_valid = lv; ib.lookup_pc = pc; ib.upd_valid = uv;
    ib.upd_index = ui; ib.upd_taken = ut; ib.upd_mispredict = um;
    @(posedge clk);
    @(negedge clk);
    ia.lookup_valid = 1'b0; ia.upd_valid = 1'b0; ia.upd_mispredict = 1'b0;
    ib.lookup_valid = 1'b0; ib.upd_valid = 1'b0; ib.upd_mispredict = 1'b0;
  endtask
  initial begin
    rst = 1'b0;
    ia.lookup_valid = 1'b0; ia.lookup_pc = '0; ia.upd_valid = 1'b0;
    ia.upd_index = '0; ia.upd_taken = 1'b0; ia.upd_mispredict = 1'b0;
    ib.lookup_valid = 1'b0; ib.lookup_pc = '0; ib.upd_valid = 1'b0;
    ib.upd_index = '0; ib.upd_taken = 1'b0; ib.upd_mispredict = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ia.pred_valid), 0);
    chk("rst_taken", 32'(ia.pred_taken), 1);
    chk("rst_strong", 32'(ia.pred_strong), 0);
    chk("rst_index", 32'(ia.pred_index), 0);
    chk("rst_miss", 32'(ia.miss_count), 0);
    rst = 1'b1;
    drive(1, 32'h100, 1, 6'd0, 1, 1);
    chk("pre_rst_valid", 32'(ia.pred_valid), 1);
    chk("pre_rst_miss", 32'(ia.miss_count), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_miss", 32'(ia.miss_count), 0);
    chk("async_rst_valid", 32'(ia.pred_valid), 0);
    chk("async_rst_taken", 32'(ia.pred_taken), 1);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h100, 0, 6'd0, 0, 0);
    chk("post_rst_valid", 32'(ia.pred_valid), 1);
    chk("post_rst_taken", 32'(ia.pred_taken), 1);
    chk("post_rst_strong", 32'(ia.pred_strong), 0);
    chk("post_rst_index", 32'(ia.pred_index), 0);
    chk("post_rst_miss", 32'(ia.miss_count), 0);
    drive(0, 32'h0, 0, 6'd0, 0, 0);
    chk("idle_valid", 32'(ia.pred_valid), 0);
    chk("idle_hold_taken", 32'(ia.pred_taken), 1);
    repeat (3) drive(0, 32'h0, 1, 6'd5, 1, 0);
    drive(1, 32'h14, 0, 6'd0, 0, 0);
    chk("sat_hi_taken", 32'(ia.pred_taken), 1);
    chk("sat_hi_strong", 32'(ia.pred_strong), 1);
    chk("sat_hi_index", 32'(ia.pred_index), 5);
    drive(0, 32'h0, 1, 6'd5, 0, 0);
    drive(1, 32'h14, 0, 6'd0, 0, 0);
    chk("weak_taken", 32'(ia.pred_taken), 1);
    chk("weak_strong", 32'(ia.pred_strong), 0);
    repeat (4) drive(0, 32'h0, 1, 6'd5, 0, 0);
    drive(1, 32'h14, 0, 6'd0, 0, 0);
    chk("sat_lo_taken", 32'(ia.pred_taken), 0);
    chk("sat_lo_strong", 32'(ia.pred_strong), 1);
    drive(0, 32'h0, 1, 6'd5, 1, 0);
    drive(1, 32'h14, 0, 6'd0, 0, 0);
    chk("pinned_zero_taken", 32'(ia.pred_taken), 0);
    chk("pinned_zero_strong", 32'(ia.pred_strong), 0);
    drive(1, 32'h1C, 1, 6'd7, 0, 0);
    chk("bypass_taken", 32'(ia.pred_taken), 0);
    chk("bypass_strong", 32'(ia.pred_strong), 0);
    chk("bypass_index", 32'(ia.pred_index), 7);
    drive(0, 32'h0, 0, 6'd0, 0, 0);
    chk("bypass_hold_taken", 32'(ia.pred_taken), 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 32'h0, 1, 6'd0, 1, 0);
    drive(0, 32'h0, 1, 6'd0, 1, 0);
    drive(0, 32'h0, 1, 6'd0, 0, 0);
    drive(0, 32'h0, 1, 6'd0, 1, 0);
    drive(1, 32'h40, 0, 6'd0, 0, 0);
    chk("gshare_index", 32'(ib.pred_index), 32'h1D);
    chk("gshare_taken", 32'(ib.pred_taken), 1);
    chk("bimodal_index", 32'(ia.pred_index), 32'h10);
    drive(1, 32'h40, 1, 6'd0, 1, 0);
    chk("gshare_preshift_index", 32'(ib.pred_index), 32'h1D);
    drive(1, 32'h40, 0, 6'd0, 0, 0);
    chk("gshare_shifted_index", 32'(ib.pred_index), 32'h1B);
    repeat (4) drive(0, 32'h0, 1, 6'd0, 0, 0);
    drive(1, 32'h200, 0, 6'd0, 0, 0);
    chk("alias_taken", 32'(ia.pred_taken), 0);
    chk("alias_strong", 32'(ia.pred_strong), 1);
    chk("alias_index", 32'(ia.pred_index), 0);
    repeat (2) drive(0, 32'h0, 1, 6'd10, 1, 1);
    chk("miss_two", 32'(ia.miss_count), 2);
    drive(0, 32'h0, 0, 6'd10, 1, 1);
    chk("miss_ignored", 32'(ia.miss_count), 2);
    repeat (7) drive(0, 32'h0, 1, 6'd10, 1, 1);
    chk("miss_sat", 32'(ia.miss_count), 7);
    chk("miss_wide", 32'(ib.miss_count), 9);
    drive(0, 32'h0, 1, 6'd10, 1, 1);
    chk("miss_sat_hold", 32'(ia.miss_count), 7);
    drive(0, 32'h0, 0, 6'd10, 1, 1);
    chk("miss_wide_ignored", 32'(ib.miss_count), 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bht_predictor.md
# bht_predictor

Parametrised branch history table: an array of 2^INDEX_BITS saturating counters, each CTR_BITS wide, indexed by PC bits, optionally XOR-hashed with a global history register (gshare).
- Serves the fetch/decode stage with a registered taken/not-taken prediction.
- Is trained from the execute stage, with the branch-type and branch-resolved flags driving the update port.
- Replaces the single-counter 2-bit predictor and keeps the same reset-to-weakly-taken policy.

## Interface
- CTR_BITS, 2, counter width (≥2); taken when MSB=1
- INDEX_BITS, 6, table index width; 2^INDEX_BITS entries
- GHR_BITS, 0, global history length (0..INDEX_BITS); 0 = pure bimodal
- PC_WIDTH, 32, PC width
- PC_LSB, 2, lowest PC bit used in the index
- MISS_CNT_BITS, 16, width of the mispredict statistics counter

- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- lookup_valid  in  1  prediction request
- lookup_pc  in  PC_WIDTH  PC of the fetched instruction
- pred_valid  out  1  registered prediction valid
- pred_taken  out  1  predicted direction
- pred_strong  out  1  counter is saturated (all-ones or all-zeros)
- pred_index  out  INDEX_BITS  table index used; carried down the pipe to the update port
- upd_valid  in  1  resolved branch (branch instruction in execute)
- upd_index  in  INDEX_BITS  index returned with that branch's prediction
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  pipeline reports a mispredict for this branch
- miss_count  out  MISS_CNT_BITS  saturating mispredict count

## Operation
- Index: `lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB] ^ {zero-extended ghr}`; when GHR_BITS=0 there is no XOR term.
- Reset (rst=0, asynchronous):
  - every counter = 2^(CTR_BITS-1), i.e. weakly taken (2'b10 for CTR_BITS=2);
  - ghr = 0, pred_valid = 0, pred_taken = 1, pred_strong = 0, pred_index = 0, miss_count = 0.
- Update (upd_valid=1), applied at the clock edge:
  - counter[upd_index] increments when upd_taken=1, saturating at 2^CTR_BITS-1;
  - it decrements when upd_taken=0, saturating at 0.
- GHR (GHR_BITS>0): on upd_valid, `ghr <= {ghr[GHR_BITS-2:0], upd_taken}`. Training is non-speculative; the ghr never changes on lookup.
- miss_count increments when `upd_valid & upd_mispredict`, and holds at all-ones.
- upd_mispredict is ignored when upd_valid=0.
- Lookup uses the ghr value present in the request cycle, before any same-edge shift.
- Same-index bypass: if lookup_valid and upd_valid occur in the same cycle and the computed index == upd_index, the prediction reflects the post-update counter value.
- No lookup: pred_valid=0. pred_taken, pred_strong and pred_index hold their last values.

## Timing
- Lookup latency is 1 cycle: a request at edge N produces pred_* valid after edge N+1, for exactly one cycle per request.
- Back-to-back lookups are accepted every cycle; there is no stall or backpressure.
- An update is visible to a lookup issued in the same cycle (through the bypass) and to every later lookup.
- Reset asserted mid-operation clears state immediately, with no clock needed. The first lookup is accepted on the first edge after reset is released.
- Width rules:
  - index arithmetic is modulo 2^INDEX_BITS;
  - PC bits above PC_LSB+INDEX_BITS-1 and below PC_LSB are ignored (aliasing is intended);
  - counter values never wrap.

## Test plan
- **Reset:** drive rst=0 mid-stream, then release; lookup PC=0x100 → pred_valid=1 one cycle later, pred_taken=1, pred_strong=0, miss_count=0.
- **Saturation (CTR_BITS=2, GHR_BITS=0):**
  - 3 taken updates to index 0x05 → lookup PC=0x14 gives taken, strong;
  - then 1 not-taken update → taken, weak;
  - then 4 not-taken updates → not-taken, strong, with the counter pinned at 0.
- **Same-cycle bypass:** index 0x07 at counter 2'b10; same cycle, upd_valid (not-taken) to 0x07 and lookup PC=0x1C → pred_taken=0 next cycle.
- **Gshare (GHR_BITS=4, INDEX_BITS=6):** updates taken, taken, not-taken, taken → ghr=4'b1101; lookup PC=0x40 → pred_index=0x10^0x0D=0x1D.
- **Aliasing:** train PC=0x100 strongly not-taken; lookup PC=0x200 (same index with INDEX_BITS=6, PC_LSB=2) → pred_taken=0, pred_index equal to that of 0x100.
- **Mispredict counter (MISS_CNT_BITS=3):**
  - 9 cycles with upd_valid=upd_mispredict=1 → miss_count=7 (saturated);
  - upd_mispredict=1 with upd_valid=0 → no change.
